// File: rtl/dmem_dump.sv
// rtl/dmem_dump.sv - host-side reader that streams a run of dmem words out as bytes
//
// Purpose:
//   On a start command, this block requests the data SRAM port from the core
//   and reads word_cnt consecutive words starting at base_addr. It emits each
//   word as four bytes, LSB first, over a valid/ready byte stream that feeds
//   the debug UART TX.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   start_i                    one-cycle command strobe, sampled only in IDLE
//   base_addr_i, word_cnt_i    dump parameters, captured on an accepted start
//   busy_o, done_o             status; done_o is a one-cycle completion pulse
//   hold_req_o, hold_gnt_i     core stall handshake; the port is owned while the grant is high
//   sram_*                     read-only SRAM port (web tied high, din tied low)
//   tx_data_o/valid_o/ready_i  byte stream out
module dmem_dump #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   word_cnt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  hold_req_o,
  input  logic                  hold_gnt_i,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [ADDR_WIDTH:0]   sram_addr_o,
  output logic [31:0]           sram_din_o,
  input  logic [31:0]           sram_dout_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [31:0]           shift_q;
  logic [1:0]            byte_idx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  hold_req_q;
  logic                  tx_valid_q;

  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH:0]   cnt_d;

  // Address wraps modulo 2^ADDR_WIDTH through natural overflow.
  assign addr_d = addr_q + ADDR_WIDTH'(1);
  assign cnt_d  = cnt_q - (ADDR_WIDTH + 1)'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_req_q <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (word_cnt_i == '0) begin
              // Empty dump: finish without ever touching the core.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_REQ;
              addr_q     <= base_addr_i;
              cnt_q      <= word_cnt_i;
              busy_q     <= 1'b1;
              hold_req_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (hold_gnt_i) state_q <= S_RD;
        end
        S_RD: begin
          // The read is issued only in a cycle where the grant is present.
          if (hold_gnt_i) state_q <= S_CAP;
        end
        S_CAP: begin
          shift_q    <= sram_dout_i;
          byte_idx_q <= 2'd0;
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready_i) begin
            shift_q    <= {8'h00, shift_q[31:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              addr_q     <= addr_d;
              cnt_q      <= cnt_d;
              if (cnt_d == '0) begin
                state_q    <= S_DONE;
                done_q     <= 1'b1;
                busy_q     <= 1'b0;
                hold_req_q <= 1'b0;
              end else begin
                state_q <= S_RD;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Chip select must be low during the RD cycle itself so the word is
  // sampled at the end of RD and captured at the end of CAP; it therefore
  // follows the live grant rather than a register.
  assign sram_csb_o  = !((state_q == S_RD) && hold_gnt_i);
  assign sram_web_o  = 1'b1;
  assign sram_addr_o = {1'b0, addr_q};
  assign sram_din_o  = 32'h0;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign hold_req_o = hold_req_q;
  assign tx_valid_o = tx_valid_q;
  // Shift register only moves on a handshake, so the byte is held during a stall.
  assign tx_data_o  = shift_q[7:0];

endmodule

// File: tb/tb_dmem_dump.sv
// tb/tb_dmem_dump.sv - directed self-checking bench for dmem_dump
module tb_dmem_dump;

  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_cnt;
  logic          busy_o;
  logic          done_o;
  logic          hold_req_o;
  logic          hold_gnt;
  logic          sram_csb_o;
  logic          sram_web_o;
  logic [AW:0]   sram_addr_o;
  logic [31:0]   sram_din_o;
  logic [31:0]   sram_dout;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready;

  int vectors;
  int miscompares;

  logic [31:0] mem [0:(1<<AW)-1];
  int          done_cnt;
  bit          hold_seen;
  bit          valid_seen;
  int          rd_addrs[$];

  dmem_dump #(.ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .word_cnt_i  (word_cnt),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .hold_req_o  (hold_req_o),
    .hold_gnt_i  (hold_gnt),
    .sram_csb_o  (sram_csb_o),
    .sram_web_o  (sram_web_o),
    .sram_addr_o (sram_addr_o),
    .sram_din_o  (sram_din_o),
    .sram_dout_i (sram_dout),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: address/csb sampled at one edge, data valid for the next.
  always @(posedge clk) begin
    if (!sram_csb_o) sram_dout <= mem[sram_addr_o[AW-1:0]];
  end

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (hold_req_o) hold_seen = 1'b1;
    if (tx_valid_o) valid_seen = 1'b1;
    if (!sram_csb_o) rd_addrs.push_back(int'(sram_addr_o));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a handshake cycle, check the byte, then consume it.
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!(tx_valid_o && tx_ready) && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_hs"}, 32'(tx_valid_o && tx_ready), 32'd1);
    chk(tag, 32'(tx_data_o), 32'(exp));
    step();
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] c);
    start     = 1'b1;
    base_addr = b;
    word_cnt  = c;
    step();
    start     = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    hold_seen   = 1'b0;
    valid_seen  = 1'b0;
    sram_dout   = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    start     = 1'b0;
    base_addr = '0;
    word_cnt  = '0;
    hold_gnt  = 1'b0;
    tx_ready  = 1'b0;
    rst_n     = 1'b0;

    // Reset values
    step(); step();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_hold", 32'(hold_req_o), 32'd0);
    chk("rst_csb", 32'(sram_csb_o), 32'd1);
    chk("rst_web", 32'(sram_web_o), 32'd1);
    chk("rst_addr", 32'(sram_addr_o), 32'd0);
    chk("rst_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_data", 32'(tx_data_o), 32'd0);
    rst_n = 1'b1;
    step();

    // Single word, exact cycle timing
    mem[3]   = 32'hDEADBEEF;
    hold_gnt = 1'b1;
    tx_ready = 1'b1;
    pulse_start(5'd3, 6'd1);
    chk("t1_req_hold", 32'(hold_req_o), 32'd1);
    chk("t1_req_busy", 32'(busy_o), 32'd1);
    chk("t1_req_csb", 32'(sram_csb_o), 32'd1);
    step();
    chk("t1_rd_csb", 32'(sram_csb_o), 32'd0);
    chk("t1_rd_addr", 32'(sram_addr_o), 32'd3);
    chk("t1_rd_web", 32'(sram_web_o), 32'd1);
    step();
    chk("t1_cap_csb", 32'(sram_csb_o), 32'd1);
    chk("t1_cap_valid", 32'(tx_valid_o), 32'd0);
    step();
    chk("t1_b0_valid", 32'(tx_valid_o), 32'd1);
    chk("t1_b0", 32'(tx_data_o), 32'hEF);
    step();
    chk("t1_b1", 32'(tx_data_o), 32'hBE);
    step();
    chk("t1_b2", 32'(tx_data_o), 32'hAD);
    step();
    chk("t1_b3_valid", 32'(tx_valid_o), 32'd1);
    chk("t1_b3", 32'(tx_data_o), 32'hDE);
    step();
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_busy_end", 32'(busy_o), 32'd0);
    chk("t1_hold_end", 32'(hold_req_o), 32'd0);
    chk("t1_valid_end", 32'(tx_valid_o), 32'd0);
    step();
    chk("t1_done_pulse", 32'(done_o), 32'd0);

    // Three words across the address wrap
    mem[30] = 32'h11111111;
    mem[31] = 32'h22222222;
    mem[0]  = 32'h33333333;
    rd_addrs.delete();
    pulse_start(5'd30, 6'd3);
    for (int i = 0; i < 4; i++) expect_byte("t2_w0", 8'h11);
    for (int i = 0; i < 4; i++) expect_byte("t2_w1", 8'h22);
    for (int i = 0; i < 4; i++) expect_byte("t2_w2", 8'h33);
    chk("t2_done", 32'(done_o), 32'd1);
    step();
    chk("t2_nreads", 32'(rd_addrs.size()), 32'd3);
    if (rd_addrs.size() == 3) begin
      chk("t2_addr0", 32'(rd_addrs[0]), 32'd30);
      chk("t2_addr1", 32'(rd_addrs[1]), 32'd31);
      chk("t2_addr2", 32'(rd_addrs[2]), 32'd0);
    end

    // Zero-length dump
    step();
    hold_seen  = 1'b0;
    valid_seen = 1'b0;
    pulse_start(5'd7, 6'd0);
    chk("t3_done", 32'(done_o), 32'd1);
    chk("t3_busy", 32'(busy_o), 32'd0);
    step();
    chk("t3_done_pulse", 32'(done_o), 32'd0);
    step();
    chk("t3_no_hold", 32'(hold_seen), 32'd0);
    chk("t3_no_valid", 32'(valid_seen), 32'd0);

    // Delayed grant
    mem[5]   = 32'hA5C30F96;
    hold_gnt = 1'b0;
    rd_addrs.delete();
    pulse_start(5'd5, 6'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_wait_hold", 32'(hold_req_o), 32'd1);
      chk("t4_wait_csb", 32'(sram_csb_o), 32'd1);
      step();
    end
    hold_gnt = 1'b1;
    step();
    chk("t4_rd_csb", 32'(sram_csb_o), 32'd0);
    chk("t4_rd_addr", 32'(sram_addr_o), 32'd5);
    expect_byte("t4_b0", 8'h96);
    expect_byte("t4_b1", 8'h0F);
    expect_byte("t4_b2", 8'hC3);
    expect_byte("t4_b3", 8'hA5);
    chk("t4_done", 32'(done_o), 32'd1);
    chk("t4_nreads", 32'(rd_addrs.size()), 32'd1);
    step();

    // Back-pressure on the second byte with a start pulsed during the stall
    mem[7] = 32'h44332211;
    mem[8] = 32'h88776655;
    rd_addrs.delete();
    pulse_start(5'd7, 6'd2);
    expect_byte("t5_b0", 8'h11);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_stall_valid", 32'(tx_valid_o), 32'd1);
      chk("t5_stall_data", 32'(tx_data_o), 32'h22);
      if (i == 1) begin
        start     = 1'b1;
        base_addr = 5'd0;
        word_cnt  = 6'd5;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    expect_byte("t5_b1", 8'h22);
    expect_byte("t5_b2", 8'h33);
    expect_byte("t5_b3", 8'h44);
    expect_byte("t5_b4", 8'h55);
    expect_byte("t5_b5", 8'h66);
    expect_byte("t5_b6", 8'h77);
    expect_byte("t5_b7", 8'h88);
    chk("t5_done", 32'(done_o), 32'd1);
    step();
    chk("t5_idle_busy", 32'(busy_o), 32'd0);
    chk("t5_nreads", 32'(rd_addrs.size()), 32'd2);
    if (rd_addrs.size() == 2) begin
      chk("t5_addr0", 32'(rd_addrs[0]), 32'd7);
      chk("t5_addr1", 32'(rd_addrs[1]), 32'd8);
    end

    // Reset mid-dump, then a fresh dump
    mem[10] = 32'hCAFEF00D;
    mem[11] = 32'h12345678;
    pulse_start(5'd10, 6'd4);
    expect_byte("t6_b0", 8'h0D);
    done_cnt = 0;
    rst_n    = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    chk("t6_rst_hold", 32'(hold_req_o), 32'd0);
    chk("t6_rst_valid", 32'(tx_valid_o), 32'd0);
    chk("t6_rst_data", 32'(tx_data_o), 32'd0);
    chk("t6_rst_csb", 32'(sram_csb_o), 32'd1);
    chk("t6_rst_addr", 32'(sram_addr_o), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    chk("t6_idle_valid", 32'(tx_valid_o), 32'd0);
    mem[0] = 32'h04030201;
    pulse_start(5'd0, 6'd1);
    expect_byte("t6_n0", 8'h01);
    expect_byte("t6_n1", 8'h02);
    expect_byte("t6_n2", 8'h03);
    expect_byte("t6_n3", 8'h04);
    chk("t6_done", 32'(done_o), 32'd1);
    step();
    chk("t6_done_pulse", 32'(done_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
